ro_count_tx: RTL and testbench

RO_COUNT_TX -- requirements
Module: ro_count_tx

---
 rtl/ro_count_tx.sv | 140 ++++++++++++++
 tb/tb_ro_count_tx.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_count_tx.sv
// Ring-oscillator count UART transmitter: 8N1 or 8E1 framing,
// one-entry holding register so frames can go out back to back.
module ro_count_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  value_in,
  input  logic        value_valid,
  output logic        value_ready,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frames_sent,
  output logic        ovf_seen
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [9:0] LAST = 10'(CLKS_PER_BIT - 1);

  state_t      state_q;
  logic [9:0]  timer_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  hold_q;
  logic        hold_full_q;
  logic        tx_q;
  logic [15:0] frames_q;
  logic        ovf_q;

  logic xfer;
  logic tick;
  logic stop_end;

  assign xfer     = value_valid & ~hold_full_q;
  assign tick     = (timer_q == LAST);
  assign stop_end = (state_q == STOP) & tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      frames_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (xfer && value_in == 8'hFF)
        ovf_q <= 1'b1;

      // A transfer landing on the STOP edge bypasses the holding register
      if (xfer && state_q != IDLE && !stop_end) begin
        hold_q      <= value_in;
        hold_full_q <= 1'b1;
      end

      if (state_q != IDLE)
        timer_q <= tick ? '0 : timer_q + 10'd1;

      unique case (state_q)
        IDLE: begin
          timer_q <= '0;
          if (xfer) begin
            shift_q <= value_in;
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state_q <= DATA;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (idx_q == 3'd7) begin
              if (PARITY_EN) begin
                state_q <= PARITY;
                tx_q    <= ^shift_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 3'd1;
              tx_q  <= shift_q[idx_q + 3'd1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            frames_q <= frames_q + 16'd1;
            if (hold_full_q) begin
              shift_q     <= hold_q;
              hold_full_q <= 1'b0;
              state_q     <= START;
              tx_q        <= 1'b0;
            end else if (xfer) begin
              shift_q <= value_in;
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign value_ready = ~hold_full_q;
  assign tx          = tx_q;
  assign busy        = (state_q != IDLE) | hold_full_q;
  assign frames_sent = frames_q;
  assign ovf_seen    = ovf_q;

endmodule

// File: tb/tb_ro_count_tx.sv
// Directed and randomized checks of ro_count_tx framing, handoff,
// reset abort, counter wrap and a serial decoder scoreboard.
module tb_ro_count_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  value_in = '0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic        tx;
  logic        busy;
  logic [15:0] frames_sent;
  logic        ovf_seen;

  logic [7:0]  value_in1 = '0;
  logic        value_valid1 = 1'b0;
  logic        value_ready1;
  logic        tx1;
  logic        busy1;
  logic [15:0] frames_sent1;
  logic        ovf_seen1;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  ro_count_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .value_in(value_in), .value_valid(value_valid),
    .value_ready(value_ready), .tx(tx), .busy(busy),
    .frames_sent(frames_sent), .ovf_seen(ovf_seen)
  );

  ro_count_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n),
    .value_in(value_in1), .value_valid(value_valid1),
    .value_ready(value_ready1), .tx(tx1), .busy(busy1),
    .frames_sent(frames_sent1), .ovf_seen(ovf_seen1)
  );

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({tx, value_ready, busy, ovf_seen} !== 4'b1100) begin
      $display("FAIL reset_flags got %b want 1100",
               {tx, value_ready, busy, ovf_seen});
    end else pass_cnt++;
    total_cnt++;
    if (frames_sent !== 16'd0) begin
      $display("FAIL reset_frames got %0h want 0", frames_sent);
    end else pass_cnt++;
    total_cnt++;
    if ({tx1, value_ready1, busy1, ovf_seen1} !== 4'b1100) begin
      $display("FAIL reset_flags1 got %b want 1100",
               {tx1, value_ready1, busy1, ovf_seen1});
    end else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_single_a5();
    logic [10:0] exp;
    exp = {1'b1, 1'b0, 8'hA5, 1'b0};
    @(negedge clk);
    value_in = 8'hA5;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    for (int k = 0; k < 11; k++) begin
      total_cnt++;
      if (tx !== exp[k]) begin
        $display("FAIL a5_bit%0d_head got %b want %b", k, tx, exp[k]);
      end else pass_cnt++;
      repeat (3) @(negedge clk);
      total_cnt++;
      if (tx !== exp[k]) begin
        $display("FAIL a5_bit%0d_tail got %b want %b", k, tx, exp[k]);
      end else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if (frames_sent !== 16'd1) begin
      $display("FAIL a5_frames got %0h want 1", frames_sent);
    end else pass_cnt++;
    total_cnt++;
    if ({tx, busy, value_ready} !== 3'b101) begin
      $display("FAIL a5_idle got %b want 101", {tx, busy, value_ready});
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [21:0] exp;
    exp = {1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0};
    @(negedge clk);
    value_in = 8'h01;
    value_valid = 1'b1;
    @(negedge clk);
    value_in = 8'h80;
    @(negedge clk);
    total_cnt++;
    if ({value_ready, busy} !== 2'b01) begin
      $display("FAIL b2b_held got %b want 01", {value_ready, busy});
    end else pass_cnt++;
    value_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 22; k++) begin
      total_cnt++;
      if (tx !== exp[k]) begin
        $display("FAIL b2b_bit%0d got %b want %b", k, tx, exp[k]);
      end else pass_cnt++;
      if (k == 5) begin
        total_cnt++;
        if (value_ready !== 1'b0) begin
          $display("FAIL b2b_ready_mid got %b want 0", value_ready);
        end else pass_cnt++;
      end
      if (k == 11) begin
        total_cnt++;
        if ({value_ready, frames_sent} !== {1'b1, 16'd2}) begin
          $display("FAIL b2b_handoff got %b/%0d want 1/2",
                   value_ready, frames_sent);
        end else pass_cnt++;
      end
      repeat (4) @(negedge clk);
    end
    total_cnt++;
    if ({frames_sent, busy, tx} !== {16'd3, 1'b0, 1'b1}) begin
      $display("FAIL b2b_end got %0d/%b/%b want 3/0/1",
               frames_sent, busy, tx);
    end else pass_cnt++;
  endtask

  task automatic test_parity_off();
    logic [9:0] exp;
    exp = {1'b1, 8'hFF, 1'b0};
    @(negedge clk);
    value_in1 = 8'hFF;
    value_valid1 = 1'b1;
    @(negedge clk);
    value_valid1 = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      total_cnt++;
      if (tx1 !== exp[k]) begin
        $display("FAIL nopar_bit%0d got %b want %b", k, tx1, exp[k]);
      end else pass_cnt++;
      repeat (4) @(negedge clk);
    end
    total_cnt++;
    if ({frames_sent1, ovf_seen1, busy1} !== {16'd1, 1'b1, 1'b0}) begin
      $display("FAIL nopar_end got %0d/%b/%b want 1/1/0",
               frames_sent1, ovf_seen1, busy1);
    end else pass_cnt++;
    total_cnt++;
    if (ovf_seen !== 1'b0) begin
      $display("FAIL ovf_other got %b want 0", ovf_seen);
    end else pass_cnt++;
    value_in1 = 8'h00;
    value_valid1 = 1'b1;
    @(negedge clk);
    value_valid1 = 1'b0;
    repeat (44) @(negedge clk);
    total_cnt++;
    if ({frames_sent1, ovf_seen1, value_ready1} !== {16'd2, 1'b1, 1'b1}) begin
      $display("FAIL ovf_sticky got %0d/%b/%b want 2/1/1",
               frames_sent1, ovf_seen1, value_ready1);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [10:0] exp;
    exp = {1'b1, 1'b0, 8'h5A, 1'b0};
    @(negedge clk);
    value_in = 8'hC3;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    repeat (17) @(negedge clk);
    total_cnt++;
    if (tx !== 1'b0) begin
      $display("FAIL mid_data_bit3 got %b want 0", tx);
    end else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({tx, value_ready, busy, frames_sent} !== {3'b110, 16'd0}) begin
      $display("FAIL mid_abort got %b/%b/%b/%0d want 1/1/0/0",
               tx, value_ready, busy, frames_sent);
    end else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    value_in = 8'h5A;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      total_cnt++;
      if (tx !== exp[k]) begin
        $display("FAIL post_rst_bit%0d got %b want %b", k, tx, exp[k]);
      end else pass_cnt++;
      repeat (4) @(negedge clk);
    end
    total_cnt++;
    if (frames_sent !== 16'd1) begin
      $display("FAIL post_rst_frames got %0d want 1", frames_sent);
    end else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [15:0] exp [3];
    exp[0] = 16'hFFFF;
    exp[1] = 16'h0000;
    exp[2] = 16'h0001;
    @(negedge clk);
    force u0.frames_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release u0.frames_q;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      value_in = 8'(i);
      value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      repeat (44) @(negedge clk);
      total_cnt++;
      if (frames_sent !== exp[i]) begin
        $display("FAIL wrap%0d got %0h want %0h", i, frames_sent, exp[i]);
      end else pass_cnt++;
    end
  endtask

  task automatic produce();
    int bound;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 12)) begin
        @(negedge clk);
        value_valid = 1'b0;
        value_in = 8'($urandom);
      end
      @(negedge clk);
      value_in = 8'($urandom);
      value_valid = 1'b1;
      bound = 0;
      while (!value_ready && bound < 200) begin
        @(negedge clk);
        bound++;
      end
      if (bound >= 200) begin
        total_cnt++;
        $display("FAIL rnd_ready_timeout got 0 want 1");
        break;
      end
      sb_q.push_back(value_in);
    end
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic decode();
    int got = 0;
    int idle = 0;
    logic [7:0] d;
    logic [7:0] e;
    logic p;
    logic s;
    while (got < 1000 && idle < 5000) begin
      @(negedge clk);
      if (tx == 1'b0) begin
        repeat (2) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (4) @(negedge clk);
          d[b] = tx;
        end
        repeat (4) @(negedge clk);
        p = tx;
        repeat (4) @(negedge clk);
        s = tx;
        @(negedge clk);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : ~d;
        total_cnt++;
        if ({s, p, d} !== {1'b1, ^e, e}) begin
          $display("FAIL rnd_frame%0d got %b want %b",
                   got, {s, p, d}, {1'b1, ^e, e});
        end else pass_cnt++;
        got++;
        idle = 0;
      end else begin
        idle++;
      end
    end
    if (got < 1000) begin
      total_cnt++;
      $display("FAIL rnd_decoded got %0d want 1000", got);
    end
  endtask

  task automatic test_random();
    fork
      produce();
      decode();
    join
    repeat (4) @(negedge clk);
    total_cnt++;
    if ({frames_sent, busy} !== {16'd1001, 1'b0}) begin
      $display("FAIL rnd_end got %0d/%b want 1001/0", frames_sent, busy);
    end else pass_cnt++;
    total_cnt++;
    if (sb_q.size() !== 0) begin
      $display("FAIL rnd_leftover got %0d want 0", sb_q.size());
    end else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_parity_off();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
